// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue behind the register-rename stage.
// Instructions are dispatched at the tail, marked done by ROB tag when they
// complete, and retired from the head in program order, one per cycle. Each
// retirement returns the displaced physical register to the rename free list.
// Optional build macro ROB_ERR_CHECK_EN adds a sticky rob_err output that flags
// protocol misuse: completion to an invalid or already-done entry, or
// dispatch_valid while the ROB is full.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic              dispatch_has_rd,
  input  logic [4:0]        dispatch_arch_rd,
  input  logic [PREG_W-1:0] dispatch_phys_rd,
  input  logic [PREG_W-1:0] dispatch_old_phys_rd,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  output logic              retire_insn,
  output logic              retire_valid,
  output logic [PREG_W-1:0] retire_phys_reg,
  output logic [4:0]        retire_arch_rd,
  output logic [TAG_W:0]    rob_count,
  output logic              rob_empty
`ifdef ROB_ERR_CHECK_EN
  ,
  output logic              rob_err
`endif
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]    head_q, head_d;
  logic [TAG_W:0]    tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;

  // Payload storage; contents are only meaningful while the entry is valid.
  logic              has_rd_q   [DEPTH];
  logic [4:0]        arch_rd_q  [DEPTH];
  logic [PREG_W-1:0] phys_rd_q  [DEPTH];
  logic [PREG_W-1:0] old_phys_q [DEPTH];

  logic              retire_insn_q, retire_valid_q;
  logic [PREG_W-1:0] retire_phys_q;
  logic [4:0]        retire_arch_q;

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              full, do_disp, do_ret;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

  // A retire in the same cycle never opens a slot: ready looks only at state.
  assign dispatch_ready = !full;
  assign dispatch_tag   = tail_idx;
  assign do_disp        = dispatch_valid && !full;
  assign do_ret         = valid_q[head_idx] && done_q[head_idx];

  // Modulo-2*DEPTH difference yields 0..DEPTH directly.
  assign rob_count = tail_q - head_q;
  assign rob_empty = (head_q == tail_q);

  assign retire_insn     = retire_insn_q;
  assign retire_valid    = retire_valid_q;
  assign retire_phys_reg = retire_phys_q;
  assign retire_arch_rd  = retire_arch_q;

  // The new mapping is kept per entry for a future recovery path; nothing in
  // this block consumes it yet.
  logic unused_phys;
  assign unused_phys = ^phys_rd_q[head_idx];

  // Next-state for pointers and per-entry valid/done flags.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (complete_valid && valid_q[complete_tag]) begin
      done_d[complete_tag] = 1'b1;
    end
    if (do_ret) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + 1'b1;
    end
    if (do_disp) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + 1'b1;
    end
  end

  // Control state: pointers and entry flags, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload capture at the tail on an accepted dispatch.
  always_ff @(posedge clk) begin
    if (do_disp) begin
      has_rd_q[tail_idx]   <= dispatch_has_rd;
      arch_rd_q[tail_idx]  <= dispatch_arch_rd;
      phys_rd_q[tail_idx]  <= dispatch_phys_rd;
      old_phys_q[tail_idx] <= dispatch_old_phys_rd;
    end
  end

  // Registered retire pulses; the payload outputs hold between retirements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_insn_q  <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_phys_q  <= '0;
      retire_arch_q  <= '0;
    end else begin
      retire_insn_q  <= do_ret;
      retire_valid_q <= do_ret && has_rd_q[head_idx];
      if (do_ret) begin
        retire_phys_q <= old_phys_q[head_idx];
        retire_arch_q <= arch_rd_q[head_idx];
      end
    end
  end

`ifdef ROB_ERR_CHECK_EN
  logic rob_err_q;
  assign rob_err = rob_err_q;

  // Sticky misuse flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_err_q <= 1'b0;
    end else if ((complete_valid && (!valid_q[complete_tag] || done_q[complete_tag])) ||
                 (dispatch_valid && full)) begin
      rob_err_q <= 1'b1;
    end
  end
`endif

endmodule
